// File: rtl/arm_mul_unit.sv
// Iterative shift-add multiplier for MUL, MLA, UMULL and SMULL.
// Retires BITS_PER_CYCLE multiplier bits per CALC cycle, then presents the
// result and N/Z flags with a one-cycle done pulse in FINAL.
// Optional build macro: MUL_EARLY_TERM_EN leaves CALC as soon as no set
// multiplier bits remain.
// WIDTH must be at least 8; BITS_PER_CYCLE must be 1, 2 or 4 and divide WIDTH.
module arm_mul_unit #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_n,
  output logic             flag_z
);

  localparam int unsigned N    = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CntW = $clog2(N + 1);
  localparam int unsigned W2   = 2 * WIDTH;

  localparam logic [1:0] OpMul   = 2'b00;
  localparam logic [1:0] OpMla   = 2'b01;
  localparam logic [1:0] OpSmull = 2'b11;

  typedef enum logic [1:0] {StIdle, StCalc, StFinal} state_e;

  state_e          state_q, state_d;
  logic [1:0]      op_q;
  logic [WIDTH-1:0] acc_q, mplier_q, mplier_nxt;
  logic            sign_q;
  logic [CntW-1:0] cnt_q;
  logic [W2-1:0]   mcand_q, mcand_nxt, partial_q, partial_nxt, addend, product;
  logic [WIDTH-1:0] lo_q, hi_q, res_lo, res_hi;
  logic            n_q, z_q, res_n, res_z;
  logic            accept, last_calc;
  logic [WIDTH-1:0] a_mag, b_mag;

  // SMULL works on magnitudes; the most negative value negates to itself,
  // which is already its correct unsigned magnitude.
  assign a_mag  = (op == OpSmull && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
  assign b_mag  = (op == OpSmull && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
  assign accept = (state_q == StIdle) && start && !flush;

  // One partial-product step: add the multiplicand for each set low multiplier bit.
  always_comb begin
    addend = '0;
    for (int unsigned j = 0; j < BITS_PER_CYCLE; j++) begin
      if (mplier_q[j]) addend = addend + (mcand_q << j);
    end
    partial_nxt = partial_q + addend;
    mcand_nxt   = mcand_q << BITS_PER_CYCLE;
    mplier_nxt  = mplier_q >> BITS_PER_CYCLE;
  end

  // Next-state logic; flush wins over everything else.
  always_comb begin
    state_d   = state_q;
    last_calc = 1'b0;
    unique case (state_q)
      StIdle: if (accept) state_d = StCalc;
      StCalc: begin
        if (flush) begin
          state_d = StIdle;
        end else if ((cnt_q == CntW'(1))
`ifdef MUL_EARLY_TERM_EN
                     || (mplier_nxt == '0)
`endif
                    ) begin
          state_d   = StFinal;
          last_calc = 1'b1;
        end
      end
      StFinal: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Final result formation from the partial product that is about to complete.
  always_comb begin
    product = sign_q ? (~partial_nxt + W2'(1)) : partial_nxt;
    res_hi  = '0;
    res_lo  = product[WIDTH-1:0];
    res_n   = 1'b0;
    res_z   = 1'b0;
    if (op_q == OpMul || op_q == OpMla) begin
      if (op_q == OpMla) res_lo = product[WIDTH-1:0] + acc_q;
      res_n = res_lo[WIDTH-1];
      res_z = (res_lo == '0);
    end else begin
      res_hi = product[W2-1:WIDTH];
      res_n  = product[W2-1];
      res_z  = (product == '0);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Operand latching, iteration datapath and held results.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q      <= OpMul;
      acc_q     <= '0;
      sign_q    <= 1'b0;
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      partial_q <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      n_q       <= 1'b0;
      z_q       <= 1'b0;
    end else begin
      if (accept) begin
        op_q      <= op;
        acc_q     <= acc;
        sign_q    <= (op == OpSmull) && (a[WIDTH-1] ^ b[WIDTH-1]);
        cnt_q     <= CntW'(N);
        mcand_q   <= {{WIDTH{1'b0}}, a_mag};
        mplier_q  <= b_mag;
        partial_q <= '0;
      end else if (state_q == StCalc && !flush) begin
        partial_q <= partial_nxt;
        mcand_q   <= mcand_nxt;
        mplier_q  <= mplier_nxt;
        cnt_q     <= cnt_q - CntW'(1);
      end
      if (last_calc) begin
        lo_q <= res_lo;
        hi_q <= res_hi;
        n_q  <= res_n;
        z_q  <= res_z;
      end
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StFinal);
  assign result_lo = lo_q;
  assign result_hi = hi_q;
  assign flag_n    = n_q;
  assign flag_z    = z_q;

endmodule

// File: tb/tb_arm_mul_unit.sv
// Randomized self-checking bench for arm_mul_unit. Two instances (1 and 4
// bits per cycle) share stimulus; results and latency come from an
// arithmetic reference model. Honors MUL_EARLY_TERM_EN in its latency model.
module tb_arm_mul_unit;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [1:0]  op;
  logic [31:0] a, b, acc;
  logic        busy1, done1, n1, z1, busy4, done4, n4, z4;
  logic [31:0] lo1, hi1, lo4, hi4;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  arm_mul_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .flush(flush), .op(op), .a(a), .b(b),
    .acc(acc), .busy(busy1), .done(done1), .result_lo(lo1), .result_hi(hi1),
    .flag_n(n1), .flag_z(z1)
  );

  arm_mul_unit #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start), .flush(flush), .op(op), .a(a), .b(b),
    .acc(acc), .busy(busy4), .done(done4), .result_lo(lo4), .result_hi(hi4),
    .flag_n(n4), .flag_z(z4)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference result from plain integer arithmetic.
  function automatic void model(input logic [1:0] mop, input logic [31:0] ma, mb, macc,
                                output logic [31:0] lo, hi, output logic n, z);
    logic [63:0] full;
    full = '0;
    hi   = '0;
    lo   = '0;
    case (mop)
      2'd0: lo = ma * mb;
      2'd1: lo = ma * mb + macc;
      2'd2: full = {32'd0, ma} * {32'd0, mb};
      default: full = $signed({{32{ma[31]}}, ma}) * $signed({{32{mb[31]}}, mb});
    endcase
    if (mop[1]) begin
      {hi, lo} = full;
      n = hi[31];
      z = (full == 64'd0);
    end else begin
      n = lo[31];
      z = (lo == 32'd0);
    end
  endfunction

  // Number of CALC cycles; done appears that many edges after the start edge.
  function automatic int ncalc(input logic [1:0] mop, input logic [31:0] mb, input int bpc);
    int          bits;
    int          c;
    logic [31:0] bm;
    bm   = (mop == 2'd3 && mb[31]) ? (32'd0 - mb) : mb;
    bits = 0;
    for (int i = 0; i < 32; i++) if (bm[i]) bits = i + 1;
`ifdef MUL_EARLY_TERM_EN
    c = (bits + bpc - 1) / bpc;
    if (c < 1) c = 1;
`else
    c = 32 / bpc;
`endif
    return c;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [1:0] mop,
                        input logic [31:0] ma, mb, macc);
    logic [31:0] elo, ehi, g_lo1, g_hi1, g_lo4, g_hi4;
    logic        en, ez, g_n1, g_z1, g_n4, g_z4;
    int          e1, e4, d1_t, d4_t, d1_n, d4_n, b1_n, b4_n;
    model(mop, ma, mb, macc, elo, ehi, en, ez);
    e1 = ncalc(mop, mb, 1);
    e4 = ncalc(mop, mb, 4);
    d1_t = -1; d4_t = -1; d1_n = 0; d4_n = 0; b1_n = 0; b4_n = 0;
    {g_lo1, g_hi1, g_lo4, g_hi4} = 'x;
    {g_n1, g_z1, g_n4, g_z4} = 'x;
    @(negedge clk);
    op = mop; a = ma; b = mb; acc = macc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if (done1) begin
        d1_n++;
        if (d1_t < 0) begin
          d1_t = t; g_lo1 = lo1; g_hi1 = hi1; g_n1 = n1; g_z1 = z1;
        end
      end
      if (done4) begin
        d4_n++;
        if (d4_t < 0) begin
          d4_t = t; g_lo4 = lo4; g_hi4 = hi4; g_n4 = n4; g_z4 = z4;
        end
      end
      if (busy1) b1_n++;
      if (busy4) b4_n++;
      @(negedge clk);
    end
    check_eq({tag, " lat1"},   64'(d1_t), 64'(e1));
    check_eq({tag, " lat4"},   64'(d4_t), 64'(e4));
    check_eq({tag, " ndone1"}, 64'(d1_n), 64'd1);
    check_eq({tag, " ndone4"}, 64'(d4_n), 64'd1);
    check_eq({tag, " busy1"},  64'(b1_n), 64'(e1 + 1));
    check_eq({tag, " busy4"},  64'(b4_n), 64'(e4 + 1));
    check_eq({tag, " res1"},   {g_hi1, g_lo1}, {ehi, elo});
    check_eq({tag, " res4"},   {g_hi4, g_lo4}, {ehi, elo});
    check_eq({tag, " nz1"},    64'({g_n1, g_z1}), 64'({en, ez}));
    check_eq({tag, " nz4"},    64'({g_n4, g_z4}), 64'({en, ez}));
    check_eq({tag, " hold1"},  {hi1, lo1}, {ehi, elo});
  endtask

  initial begin
    int d1_n;
    int d4_n;
    reset = 1'b0; start = 1'b0; flush = 1'b0; op = 2'd0; a = '0; b = '0; acc = '0;
    repeat (2) @(negedge clk);
    check_eq("reset1", 64'({busy1, done1, n1, z1, lo1, hi1}), 64'd0);
    check_eq("reset4", 64'({busy4, done4, n4, z4, lo4, hi4}), 64'd0);
    reset = 1'b1;

    run_op("mul7x6",    2'd0, 32'd7,          32'd6,          32'd0);
    run_op("smull-3x5", 2'd3, 32'hFFFF_FFFD,  32'd5,          32'd0);
    run_op("smullmin",  2'd3, 32'h8000_0000,  32'h8000_0000,  32'd0);
    run_op("smullmin1", 2'd3, 32'h8000_0000,  32'd1,          32'd0);
    run_op("umullmax",  2'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0);
    run_op("umull0",    2'd2, 32'd0,          32'd1234,       32'd0);
    run_op("mlawrap",   2'd1, 32'h0001_0000,  32'h0001_0000,  32'd5);
    run_op("mul3x2",    2'd0, 32'd3,          32'd2,          32'd0);
    run_op("mulb0",     2'd0, 32'd9,          32'd0,          32'd0);
    for (int i = 0; i < 40; i++) begin
      run_op($sformatf("rnd%0d", i), 2'($urandom_range(0, 3)), pick_operand(),
             pick_operand(), $urandom);
    end

    // Flush mid-CALC with a second start while busy; old results must hold.
    run_op("preflush", 2'd0, 32'd7, 32'd6, 32'd0);
    d1_n = 0; d4_n = 0;
    @(negedge clk);
    op = 2'd2; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if (done1) d1_n++;
      if (done4) d4_n++;
      if (t == 3) begin op = 2'd0; a = 32'd1; b = 32'd1; start = 1'b1; end
      if (t == 4) start = 1'b0;
      if (t == 8) flush = 1'b1;
      if (t == 9) begin
        flush = 1'b0;
        check_eq("flush busy1", 64'(busy1), 64'd0);
      end
      @(negedge clk);
    end
    check_eq("flush ndone1", 64'(d1_n), 64'd0);
    check_eq("flush hold1",  {hi1, lo1}, 64'd42);
    check_eq("flush ndone4", 64'(d4_n), 64'd1);
    check_eq("ignored start4", {hi4, lo4}, 64'hFFFF_FFFE_0000_0001);

    // Asynchronous reset mid-operation clears outputs without a clock edge.
    @(negedge clk);
    op = 2'd2; a = 32'h1234_5678; b = 32'h9ABC_DEF0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("pre-reset busy1", 64'(busy1), 64'd1);
    #2 reset = 1'b0;
    #1;
    check_eq("async rst1", 64'({busy1, done1, n1, z1, lo1, hi1}), 64'd0);
    check_eq("async rst4", 64'({busy4, done4, n4, z4, lo4, hi4}), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    run_op("postreset", 2'd0, 32'd7, 32'd6, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
